// File: rtl/cmult_ctrl.sv
// cmult_ctrl: sequencer for a single-multiplier complex product
// P = a*b, with a = ar + j*ai and b = br + j*bi.
// It latches one operand set, then steps the shared multiplier through
// ar*br, ai*bi, ar*bi, ai*br, and captures Pr and Pi. The result is held
// until the consumer takes it.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (accepted when both are high)
//   in_ar..in_bi           offered operands, W bits each
//   ar, ai, br, bi         latched operands to the multiplier datapath
//   a_sel, b_sel           multiplier operand select (1 = imaginary part)
//   PP1_CE, PP2_CE         partial-product register capture enables
//   add                    1 = PP1-PP2, 0 = PP1+PP2
//   PR_CE, PI_CE           result register capture enables
//   out_valid / out_ready  result handshake
//   busy                   high whenever the sequencer is not idle
module cmult_ctrl #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_ar,
  input  logic [W-1:0] in_ai,
  input  logic [W-1:0] in_br,
  input  logic [W-1:0] in_bi,
  output logic [W-1:0] ar,
  output logic [W-1:0] ai,
  output logic [W-1:0] br,
  output logic [W-1:0] bi,
  output logic         a_sel,
  output logic         b_sel,
  output logic         PP1_CE,
  output logic         PP2_CE,
  output logic         add,
  output logic         PR_CE,
  output logic         PI_CE,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] S_IDLE = SW'(0);
  localparam logic [SW-1:0] S_M1   = SW'(1);
  localparam logic [SW-1:0] S_M2   = SW'(2);
  localparam logic [SW-1:0] S_RE   = SW'(3);
  localparam logic [SW-1:0] S_M4   = SW'(4);
  localparam logic [SW-1:0] S_IM   = SW'(5);
  localparam logic [SW-1:0] S_DONE = SW'(6);

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic          accept;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch: loads only on an accepted handshake, then holds
  always_ff @(posedge clk) begin
    if (rst) begin
      ar <= '0;
      ai <= '0;
      br <= '0;
      bi <= '0;
    end else if (accept) begin
      ar <= in_ar;
      ai <= in_ai;
      br <= in_br;
      bi <= in_bi;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = in_valid ? S_M1 : S_IDLE;
      S_M1:    state_nxt = S_M2;
      S_M2:    state_nxt = S_RE;
      S_RE:    state_nxt = S_M4;
      S_M4:    state_nxt = S_IM;
      S_IM:    state_nxt = S_DONE;
      S_DONE:  state_nxt = out_ready ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    PP1_CE    = 1'b0;
    PP2_CE    = 1'b0;
    add       = 1'b0;
    PR_CE     = 1'b0;
    PI_CE     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_M1: begin
        PP1_CE = 1'b1;
      end
      S_M2: begin
        a_sel  = 1'b1;
        b_sel  = 1'b1;
        PP2_CE = 1'b1;
      end
      S_RE: begin
        // PR takes PP1-PP2 from the pre-edge registers while PP1 reloads
        add    = 1'b1;
        PR_CE  = 1'b1;
        b_sel  = 1'b1;
        PP1_CE = 1'b1;
      end
      S_M4: begin
        a_sel  = 1'b1;
        PP2_CE = 1'b1;
      end
      S_IM: begin
        PI_CE = 1'b1;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cmult_ctrl.sv
// Testbench for cmult_ctrl: behavioural multiplier datapath driven by the
// controls, directed vector table plus backpressure, reset, back-to-back
// and illegal-state sequences.
module tb_cmult_ctrl;

  localparam int unsigned W = 12;

  typedef struct {
    logic [W-1:0]   ar;
    logic [W-1:0]   ai;
    logic [W-1:0]   br;
    logic [W-1:0]   bi;
    logic [2*W-1:0] pr;
    logic [2*W-1:0] pi;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_ar, in_ai, in_br, in_bi;
  logic [W-1:0] ar, ai, br, bi;
  logic         a_sel, b_sel, pp1_ce, pp2_ce, add, pr_ce, pi_ce;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cmult_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .a_sel(a_sel), .b_sel(b_sel), .PP1_CE(pp1_ce), .PP2_CE(pp2_ce),
    .add(add), .PR_CE(pr_ce), .PI_CE(pi_ce),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  // Reference datapath: one shared multiplier, two partial-product regs,
  // and the Pr/Pi result regs, all steered by the DUT controls.
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_prod, m_pp1, m_pp2, m_pr, m_pi;

  always_comb begin
    m_a    = a_sel ? ai : ar;
    m_b    = b_sel ? bi : br;
    m_prod = (2*W)'(m_a) * (2*W)'(m_b);
  end

  always_ff @(posedge clk) begin
    if (pp1_ce) m_pp1 <= m_prod;
    if (pp2_ce) m_pp2 <= m_prod;
    if (pr_ce)  m_pr  <= add ? (m_pp1 - m_pp2) : (m_pp1 + m_pp2);
    if (pi_ce)  m_pi  <= add ? (m_pp1 - m_pp2) : (m_pp1 + m_pp2);
  end

  logic [6:0] ctrl;
  assign ctrl = {a_sel, b_sel, pp1_ce, pp2_ce, add, pr_ce, pi_ce};

  // Expected {a_sel,b_sel,PP1_CE,PP2_CE,add,PR_CE,PI_CE} for cycles 1..5
  logic [6:0] exp_ctrl [1:5];
  vec_t       vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the idle negedge
  // following DONE (out_ready held high).
  task automatic do_op(input vec_t v, input string tag);
    chk({tag, " in_ready before accept"}, 64'(in_ready), 64'(1));
    in_ar = v.ar; in_ai = v.ai; in_br = v.br; in_bi = v.bi;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("%s cycle %0d status", tag, c),
          64'({in_ready, busy, out_valid, ctrl}), 64'({3'b010, exp_ctrl[c]}));
    end
    @(negedge clk);
    chk({tag, " done status"}, 64'({in_ready, busy, out_valid, ctrl}), 64'({3'b011, 7'd0}));
    chk({tag, " pr"}, 64'(m_pr), 64'(v.pr));
    chk({tag, " pi"}, 64'(m_pi), 64'(v.pi));
    @(negedge clk);
    chk({tag, " back to idle"}, 64'({in_ready, busy, out_valid, ctrl}), 64'({3'b100, 7'd0}));
  endtask

  initial begin
    int t [3];
    vec_t vb;

    exp_ctrl[1] = 7'b0010000;
    exp_ctrl[2] = 7'b1101000;
    exp_ctrl[3] = 7'b0110110;
    exp_ctrl[4] = 7'b1001000;
    exp_ctrl[5] = 7'b0000001;

    vecs[0] = '{ar: 12'd3,     ai: 12'd4,     br: 12'd5,     bi: 12'd6,     pr: 24'hFFFFF7, pi: 24'h000026};
    vecs[1] = '{ar: 12'hFFF,   ai: 12'hFFF,   br: 12'hFFF,   bi: 12'hFFF,   pr: 24'h000000, pi: 24'hFFC002};
    vecs[2] = '{ar: 12'd0,     ai: 12'd0,     br: 12'd0,     bi: 12'd0,     pr: 24'h000000, pi: 24'h000000};
    vecs[3] = '{ar: 12'd2,     ai: 12'd3,     br: 12'd7,     bi: 12'd1,     pr: 24'h00000B, pi: 24'h000017};
    vecs[4] = '{ar: 12'd0,     ai: 12'd1,     br: 12'd0,     bi: 12'd1,     pr: 24'hFFFFFF, pi: 24'h000000};
    vecs[5] = '{ar: 12'h100,   ai: 12'h010,   br: 12'h020,   bi: 12'h800,   pr: 24'hFFA000, pi: 24'h080200};

    // Reset with in_valid high: reset wins, operands cleared
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_ar = 12'hABC; in_ai = 12'h123; in_br = 12'h456; in_bi = 12'h789;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("status during reset", 64'({in_ready, busy, out_valid, ctrl}), 64'({3'b100, 7'd0}));
    chk("operands during reset", 64'({ar, ai, br, bi}), 64'(0));
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("status after reset", 64'({in_ready, busy, out_valid, ctrl}), 64'({3'b100, 7'd0}));

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: DONE held for 10 cycles, new operands offered meanwhile
    in_ar = 12'd3; in_ai = 12'd4; in_br = 12'd5; in_bi = 12'd6;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp done reached", 64'(out_valid), 64'(1));
    in_ar = 12'd9; in_ai = 12'd9; in_br = 12'd9; in_bi = 12'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold %0d handshake", i), 64'({in_ready, busy, out_valid}), 64'(3'b011));
      chk($sformatf("bp hold %0d result", i), 64'({m_pr, m_pi}), 64'({24'hFFFFF7, 24'h000026}));
      chk($sformatf("bp hold %0d operands", i), 64'({ar, ai, br, bi}), 64'({12'd3, 12'd4, 12'd5, 12'd6}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release idle", 64'({in_ready, busy, out_valid}), 64'(3'b100));
    @(negedge clk);
    chk("bp new accept", 64'({busy, ar, ai, br, bi}), 64'({1'b1, 12'd9, 12'd9, 12'd9, 12'd9}));
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp second result", 64'({out_valid, m_pr, m_pi}), 64'({1'b1, 24'h000000, 24'h0000A2}));
    @(negedge clk);
    chk("bp second idle", 64'({in_ready, busy, out_valid}), 64'(3'b100));

    // Reset while in RE abandons the operation
    in_ar = 12'd2; in_ai = 12'd3; in_br = 12'd7; in_bi = 12'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst-in-RE reached RE", 64'(ctrl), 64'(exp_ctrl[3]));
    rst = 1'b1;
    in_valid = 1'b1; in_ar = 12'h555;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst-in-RE status", 64'({in_ready, busy, out_valid, ctrl}), 64'({3'b100, 7'd0}));
    chk("rst-in-RE operands", 64'({ar, ai, br, bi}), 64'(0));
    do_op(vecs[3], "post-reset");

    // Back-to-back with in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vb = vecs[k];
      in_ar = vb.ar; in_ai = vb.ai; in_br = vb.br; in_bi = vb.bi;
      chk($sformatf("b2b%0d in_ready", k), 64'(in_ready), 64'(1));
      t[k] = cyc;
      repeat (6) @(negedge clk);
      chk($sformatf("b2b%0d result", k), 64'({out_valid, m_pr, m_pi}), 64'({1'b1, vb.pr, vb.pi}));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b spacing 0-1", 64'(t[1] - t[0]), 64'(7));
    chk("b2b spacing 1-2", 64'(t[2] - t[1]), 64'(7));

    // Unused state encoding returns to IDLE on the next edge
    @(negedge clk);
    force dut.state = 3'd7;
    #1;
    chk("illegal state busy", 64'({in_ready, busy, out_valid}), 64'(3'b010));
    release dut.state;
    @(negedge clk);
    chk("illegal state recovery", 64'({in_ready, busy, out_valid, ctrl}), 64'({3'b100, 7'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
